// File: rtl/game_state_controller_pkg.sv
// Shared definitions for the game stages: state encoding, screen geometry
// and game-rule defaults used by the sequencer.
package game_state_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DEATH = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam int c_TILE_SIZE    = 16;
    localparam int c_SCREEN_COLS  = 40;
    localparam int c_SCREEN_ROWS  = 30;

    localparam int c_LIVES_INI_DEF = 3;
    localparam int c_MAX_LEVEL_DEF = 15;

    localparam int c_DIV_W      = 24;
    localparam int c_DIV_CALC_W = 28;

endpackage

// File: rtl/game_state_controller_if.sv
// Game-control bus between the frog/collision stages and the game sequencer.
interface game_state_controller_if;
    import game_state_controller_pkg::*;

    logic               i_Start;
    logic               i_Has_Collided;
    logic               i_Level_Up;
    logic               o_Game_Active;
    logic [1:0]         o_State;
    logic [2:0]         o_Lives;
    logic [3:0]         o_Level;
    logic [c_DIV_W-1:0] o_Car_Speed_Div;
    logic               o_Frog_Visible;
    logic               o_Game_Over;

    modport slave (
        input  i_Start, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_State, o_Lives, o_Level,
               o_Car_Speed_Div, o_Frog_Visible, o_Game_Over
    );

    modport master (
        output i_Start, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_State, o_Lives, o_Level,
               o_Car_Speed_Div, o_Frog_Visible, o_Game_Over
    );

endinterface

// File: rtl/game_state_controller_speed_divider_lut.sv
// Registered level -> car step divider, floored at c_SPEED_MIN so higher
// levels can never underflow the divider.
module speed_divider_lut
    import game_state_controller_pkg::*;
#(
    parameter int c_SPEED_BASE = 1600000,
    parameter int c_SPEED_STEP = 100000,
    parameter int c_SPEED_MIN  = 200000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic [3:0]         i_Level,
    output logic [c_DIV_W-1:0] o_Div
);

    function automatic logic [c_DIV_CALC_W-1:0] clamp_div(input logic [3:0] level);
        logic [c_DIV_CALC_W-1:0] steps;
        logic [c_DIV_CALC_W-1:0] drop;
        logic [c_DIV_CALC_W-1:0] room;
        steps = (level == 4'd0) ? '0 : c_DIV_CALC_W'(level) - c_DIV_CALC_W'(1);
        drop  = steps * c_DIV_CALC_W'(c_SPEED_STEP);
        room  = c_DIV_CALC_W'(c_SPEED_BASE) - c_DIV_CALC_W'(c_SPEED_MIN);
        // Compare the drop against the headroom so the subtraction never wraps.
        if (drop >= room) begin
            return c_DIV_CALC_W'(c_SPEED_MIN);
        end
        return c_DIV_CALC_W'(c_SPEED_BASE) - drop;
    endfunction

    logic [c_DIV_W-1:0] div_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            div_q <= c_DIV_W'(c_SPEED_BASE);
        end else begin
            div_q <= c_DIV_W'(clamp_div(i_Level));
        end
    end

    assign o_Div = div_q;

endmodule

// File: rtl/game_state_controller.sv
// Game sequencer: lives, level, post-death blink pause and game-over handling;
// feeds the game-active enable back to the frog movement stage.
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int c_LIVES_INI   = c_LIVES_INI_DEF,
    parameter int c_MAX_LEVEL   = c_MAX_LEVEL_DEF,
    parameter int c_DEATH_PAUSE = 12500000,
    parameter int c_BLINK_BIT   = 21,
    parameter int c_SPEED_BASE  = 1600000,
    parameter int c_SPEED_STEP  = 100000,
    parameter int c_SPEED_MIN   = 200000
) (
    input logic                  i_Clk,
    input logic                  i_Reset,
    game_state_controller_if.slave bus
);

    localparam int c_CNT_W = ($clog2(c_DEATH_PAUSE) > c_BLINK_BIT) ?
                             $clog2(c_DEATH_PAUSE) : c_BLINK_BIT + 1;
    localparam logic [c_CNT_W-1:0] c_PAUSE_LOAD = c_CNT_W'(c_DEATH_PAUSE - 1);

    state_e             state_q;
    logic [2:0]         lives_q;
    logic [3:0]         level_q;
    logic [c_CNT_W-1:0] pause_q;
    logic               vis_q;
    logic               start_prev_q;
    logic [c_DIV_W-1:0] div_q;

    logic               start_edge;
    logic [c_CNT_W-1:0] pause_d;

    assign start_edge = bus.i_Start & ~start_prev_q;
    assign pause_d    = pause_q - c_CNT_W'(1);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= 3'(c_LIVES_INI);
            level_q      <= 4'd1;
            pause_q      <= '0;
            vis_q        <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= bus.i_Start;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_PLAY;
                        lives_q <= 3'(c_LIVES_INI);
                        level_q <= 4'd1;
                        vis_q   <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Collision outranks a simultaneous level-up.
                    if (bus.i_Has_Collided) begin
                        if (lives_q > 3'd1) begin
                            state_q <= ST_DEATH;
                            lives_q <= lives_q - 3'd1;
                            pause_q <= c_PAUSE_LOAD;
                            vis_q   <= ~c_PAUSE_LOAD[c_BLINK_BIT];
                        end else begin
                            state_q <= ST_OVER;
                            lives_q <= 3'd0;
                            vis_q   <= 1'b0;
                        end
                    end else if (bus.i_Level_Up && (level_q < 4'(c_MAX_LEVEL))) begin
                        level_q <= level_q + 4'd1;
                    end
                end
                ST_DEATH: begin
                    if (pause_q == '0) begin
                        state_q <= ST_PLAY;
                        vis_q   <= 1'b1;
                    end else begin
                        pause_q <= pause_d;
                        vis_q   <= ~pause_d[c_BLINK_BIT];
                    end
                end
                ST_OVER: begin
                    vis_q <= 1'b0;
                    if (start_edge) begin
                        state_q <= ST_PLAY;
                        lives_q <= 3'(c_LIVES_INI);
                        level_q <= 4'd1;
                        vis_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    speed_divider_lut #(
        .c_SPEED_BASE (c_SPEED_BASE),
        .c_SPEED_STEP (c_SPEED_STEP),
        .c_SPEED_MIN  (c_SPEED_MIN)
    ) u_speed_divider_lut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Level (level_q),
        .o_Div   (div_q)
    );

    assign bus.o_State         = state_q;
    assign bus.o_Game_Active   = (state_q == ST_PLAY);
    assign bus.o_Game_Over     = (state_q == ST_OVER);
    assign bus.o_Lives         = lives_q;
    assign bus.o_Level         = level_q;
    assign bus.o_Car_Speed_Div = div_q;
    assign bus.o_Frog_Visible  = vis_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller with a short death pause (8 cycles, blink bit 1).
module tb_game_state_controller;
    import game_state_controller_pkg::*;

    localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01, S_DEATH = 2'b10, S_OVER = 2'b11;

    typedef struct {
        logic [1:0] st;
        int         lives;
        int         level;
        logic       vis;
        int         div;
    } exp_t;

    typedef struct {
        logic  rst;
        logic  start;
        logic  coll;
        logic  lu;
        exp_t  e;
        string tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[$];

    game_state_controller_if bus_if ();

    game_state_controller #(
        .c_LIVES_INI   (3),
        .c_MAX_LEVEL   (15),
        .c_DEATH_PAUSE (8),
        .c_BLINK_BIT   (1),
        .c_SPEED_BASE  (1600000),
        .c_SPEED_STEP  (100000),
        .c_SPEED_MIN   (200000)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    function automatic int spd(input int lvl);
        int v;
        v = 1600000 - (lvl - 1) * 100000;
        return (v < 200000) ? 200000 : v;
    endfunction

    function automatic logic blink(input int cnt);
        return ((cnt >> 1) & 1) == 0;
    endfunction

    function automatic exp_t mk(input logic [1:0] st, input int lives, input int level,
                                input logic vis, input int div);
        exp_t e;
        e.st = st; e.lives = lives; e.level = level; e.vis = vis; e.div = div;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".state"}, int'(bus_if.o_State), int'(e.st));
        chk({tag, ".lives"}, int'(bus_if.o_Lives), e.lives);
        chk({tag, ".level"}, int'(bus_if.o_Level), e.level);
        chk({tag, ".vis"}, int'(bus_if.o_Frog_Visible), int'(e.vis));
        chk({tag, ".div"}, int'(bus_if.o_Car_Speed_Div), e.div);
        chk({tag, ".active"}, int'(bus_if.o_Game_Active), int'(e.st == S_PLAY));
        chk({tag, ".over"}, int'(bus_if.o_Game_Over), int'(e.st == S_OVER));
    endtask

    task automatic step(input logic r, input logic s, input logic c, input logic l,
                        input exp_t e, input string tag, input bit pre_active = 1'b0);
        @(negedge clk);
        rst = r;
        bus_if.i_Start = s;
        bus_if.i_Has_Collided = c;
        bus_if.i_Level_Up = l;
        sb.push_back(e);
        if (pre_active) begin
            #1;
            chk({tag, ".active_on_coll"}, int'(bus_if.o_Game_Active), 1);
        end
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic add(input logic r, input logic s, input logic c, input logic l,
                       input exp_t e, input string tag);
        vec_t v;
        v.rst = r; v.start = s; v.coll = c; v.lu = l; v.e = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        int lvl;
        bus_if.i_Start = 1'b1;
        bus_if.i_Has_Collided = 1'b0;
        bus_if.i_Level_Up = 1'b0;

        // Start switch held through reset and beyond must not start a game.
        add(1, 1, 0, 0, mk(S_IDLE, 3, 1, 1, 1600000), "reset");
        for (int i = 0; i < 20; i++)
            add(0, 1, 0, 0, mk(S_IDLE, 3, 1, 1, 1600000), "held_start");
        add(0, 0, 0, 0, mk(S_IDLE, 3, 1, 1, 1600000), "start_low");
        add(0, 1, 0, 0, mk(S_PLAY, 3, 1, 1, 1600000), "start_edge");
        add(0, 1, 0, 0, mk(S_PLAY, 3, 1, 1, 1600000), "start_hold_play");
        for (int k = 1; k <= 16; k++) begin
            lvl = (1 + k > 15) ? 15 : 1 + k;
            add(0, 0, 0, 1, mk(S_PLAY, 3, lvl, 1, spd((k > 15) ? 15 : k)), $sformatf("lvlup%0d", k));
        end
        add(0, 0, 0, 0, mk(S_PLAY, 3, 15, 1, 200000), "lvl_sat");

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].start, vecs[i].coll, vecs[i].lu, vecs[i].e, vecs[i].tag);

        // First collision: pause with blink, stray inputs during the pause ignored.
        step(0, 0, 1, 0, mk(S_DEATH, 2, 15, blink(7), 200000), "coll1", 1'b1);
        for (int i = 1; i <= 7; i++)
            step(0, (i == 4), (i == 2), (i == 3), mk(S_DEATH, 2, 15, blink(7 - i), 200000),
                 $sformatf("death1_%0d", i));
        step(0, 0, 0, 0, mk(S_PLAY, 2, 15, 1, 200000), "death1_exit");

        step(0, 0, 1, 0, mk(S_DEATH, 1, 15, blink(7), 200000), "coll2", 1'b1);
        for (int i = 1; i <= 7; i++)
            step(0, 0, 0, 0, mk(S_DEATH, 1, 15, blink(7 - i), 200000), $sformatf("death2_%0d", i));
        step(0, 0, 0, 0, mk(S_PLAY, 1, 15, 1, 200000), "death2_exit");

        step(0, 0, 1, 0, mk(S_OVER, 0, 15, 0, 200000), "coll3_over", 1'b1);
        step(0, 0, 0, 0, mk(S_OVER, 0, 15, 0, 200000), "over_hold");
        step(0, 1, 0, 0, mk(S_PLAY, 3, 1, 1, 200000), "restart");
        step(0, 0, 0, 1, mk(S_PLAY, 3, 2, 1, spd(1)), "re_lvl2");
        step(0, 0, 0, 1, mk(S_PLAY, 3, 3, 1, spd(2)), "re_lvl3");
        step(0, 0, 0, 1, mk(S_PLAY, 3, 4, 1, spd(3)), "re_lvl4");

        // Collision and level-up together: collision wins, level held.
        step(0, 0, 1, 1, mk(S_DEATH, 2, 4, blink(7), spd(4)), "coll_and_lvl", 1'b1);
        step(0, 0, 0, 0, mk(S_DEATH, 2, 4, blink(6), spd(4)), "death3_6");
        step(0, 0, 0, 0, mk(S_DEATH, 2, 4, blink(5), spd(4)), "death3_5");
        step(1, 0, 0, 0, mk(S_IDLE, 3, 1, 1, 1600000), "reset_mid_death");
        step(0, 0, 0, 0, mk(S_IDLE, 3, 1, 1, 1600000), "after_reset");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
